// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: buffers one-cycle byte strobes and
// issues each byte with a single tx_start pulse once the previous one has finished.
module uart_tx_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     tx_busy,
  input  logic                     clr_overflow,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic push;
  logic pop;
  logic drop;

  // Flags come straight from the registered occupancy, so they lag a push/pop by one cycle.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  assign push = in_valid && !full;
  assign drop = in_valid && full;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) state_d = StStart;
      end
      StStart: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: pop, start strobe, latched byte and timeout counter
  always_comb begin
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
        end
      end
      StStart: begin
        tmo_d = '0;
      end
      StWaitBusy: begin
        if (!tx_busy && (tmo_q != TmoLast)) tmo_d = tmo_q + TmoW'(1);
      end
      StWaitDone: begin
        tmo_d = tmo_q;
      end
      default: begin
        tmo_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tmo_q      <= tmo_d;
    end
  end

  // Storage needs no reset; unread entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule
